// File: rtl/tail_lamp_scheduler.sv
// rtl/tail_lamp_scheduler.sv - tail-lamp sequencer: turn sweep, brake, hazard, auto-cancel.
// Inputs are registered once; lamps are a pure decode of the registered state.
module tail_lamp_scheduler #(
  parameter int unsigned DIV        = 4,
  parameter int unsigned CANCEL_SEQ = 8
) (
  input  logic clka,
  input  logic restart,
  input  logic brake,
  input  logic left,
  input  logic right,
  input  logic hazard,
  output logic l0,
  output logic l1,
  output logic l2,
  output logic r0,
  output logic r1,
  output logic r2,
  output logic error
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LEFT     = 3'd1,
    S_RIGHT    = 3'd2,
    S_HAZARD   = 3'd3,
    S_ERROR    = 3'd4,
    S_CANCEL_L = 3'd5,
    S_CANCEL_R = 3'd6
  } state_t;

  localparam logic [23:0] DIV_LAST   = 24'(DIV - 1);
  localparam logic [7:0]  CANCEL_CNT = 8'(CANCEL_SEQ);
  localparam logic        CANCEL_EN  = (CANCEL_SEQ != 0);

  state_t      state_q;
  state_t      mode;
  logic [23:0] presc_q;
  logic [1:0]  phase_q;
  logic [7:0]  cnt_q;
  logic        brake_q;
  logic        left_q;
  logic        right_q;
  logic        hazard_q;
  logic        tick;
  logic        legal;
  logic        match;
  logic        sequencing;
  logic        turning;
  logic [2:0]  sweep;

  always_comb begin
    mode = S_IDLE;
    if (hazard_q)               mode = S_HAZARD;
    else if (left_q && right_q) mode = S_ERROR;
    else if (left_q)            mode = S_LEFT;
    else if (right_q)           mode = S_RIGHT;
  end

  assign tick = (presc_q == DIV_LAST);

  // A cancelled turn stays cancelled while the same turn is still requested.
  always_comb begin
    legal = 1'b1;
    match = 1'b0;
    case (state_q)
      S_IDLE, S_LEFT, S_RIGHT, S_HAZARD, S_ERROR: match = (mode == state_q);
      S_CANCEL_L: match = (mode == S_LEFT);
      S_CANCEL_R: match = (mode == S_RIGHT);
      default:    legal = 1'b0;
    endcase
  end

  assign turning    = (state_q == S_LEFT) || (state_q == S_RIGHT);
  assign sequencing = turning || (state_q == S_HAZARD);

  always_ff @(posedge clka) begin
    if (restart) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
      brake_q  <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      hazard_q <= 1'b0;
    end else begin
      brake_q  <= brake;
      left_q   <= left;
      right_q  <= right;
      hazard_q <= hazard;
      if (!legal || !match) begin
        state_q <= legal ? mode : S_IDLE;
        presc_q <= '0;
        phase_q <= '0;
        cnt_q   <= '0;
      end else begin
        presc_q <= tick ? 24'd0 : presc_q + 24'd1;
        if (tick && sequencing) begin
          phase_q <= phase_q + 2'd1;
          if (turning && phase_q == 2'd3) begin
            cnt_q <= cnt_q + 8'd1;
            if (CANCEL_EN && (cnt_q + 8'd1) == CANCEL_CNT) begin
              state_q <= (state_q == S_LEFT) ? S_CANCEL_L : S_CANCEL_R;
            end
          end
        end
      end
    end
  end

  assign sweep = {phase_q != 2'd0, phase_q[1], phase_q == 2'd3};

  always_comb begin
    {l0, l1, l2} = {3{brake_q}};
    {r0, r1, r2} = {3{brake_q}};
    error        = 1'b0;
    case (state_q)
      S_LEFT:   {l0, l1, l2} = sweep;
      S_RIGHT:  {r0, r1, r2} = sweep;
      S_HAZARD: begin
        {l0, l1, l2} = {3{phase_q[0]}};
        {r0, r1, r2} = {3{phase_q[0]}};
      end
      S_ERROR:  error = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_tail_lamp_scheduler.sv
// tb/tb_tail_lamp_scheduler.sv - randomized bench against a time-since-entry lamp model.
module tb_tail_lamp_scheduler;

  localparam int DIV        = 4;
  localparam int CANCEL_SEQ = 2;

  localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3, M_ERR = 4;

  logic clka = 1'b0;
  logic restart, brake, left, right, hazard;
  logic l0, l1, l2, r0, r1, r2, error;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int m_mode   = M_IDLE;
  int m_entry  = 0;
  logic [3:0] m_rq = 4'b0;  // {brake, left, right, hazard} as registered

  tail_lamp_scheduler #(.DIV(DIV), .CANCEL_SEQ(CANCEL_SEQ)) dut (
    .clka(clka), .restart(restart), .brake(brake), .left(left), .right(right),
    .hazard(hazard), .l0(l0), .l1(l1), .l2(l2), .r0(r0), .r1(r1), .r2(r2),
    .error(error)
  );

  always #5 clka = ~clka;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs[6:0], exp[6:0]);
  endtask

  function automatic int decode(input logic [3:0] rq);
    if (rq[0])           return M_HAZ;
    if (rq[2] && rq[1])  return M_ERR;
    if (rq[2])           return M_LEFT;
    if (rq[1])           return M_RIGHT;
    return M_IDLE;
  endfunction

  // Expected {error, l0,l1,l2, r0,r1,r2} from mode and time since the mode began.
  function automatic logic [6:0] model_out();
    int         el;
    logic [1:0] ph;
    logic       b;
    logic [2:0] sig;
    logic [2:0] side;
    logic       cancelled;
    el        = cyc - m_entry;
    ph        = 2'((el / DIV) % 4);
    b         = m_rq[3];
    side      = {3{b}};
    cancelled = (CANCEL_SEQ != 0) && (el >= 4 * DIV * CANCEL_SEQ);
    case (ph)
      2'd0:    sig = 3'b000;
      2'd1:    sig = 3'b100;
      2'd2:    sig = 3'b110;
      default: sig = 3'b111;
    endcase
    case (m_mode)
      M_HAZ:   return {1'b0, {6{ph[0]}}};
      M_ERR:   return {1'b1, {6{b}}};
      M_LEFT:  return cancelled ? {1'b0, {6{b}}} : {1'b0, sig, side};
      M_RIGHT: return cancelled ? {1'b0, {6{b}}} : {1'b0, side, sig};
      default: return {1'b0, {6{b}}};
    endcase
  endfunction

  function automatic logic [6:0] observed();
    return {error, l0, l1, l2, r0, r1, r2};
  endfunction

  // v = {restart, brake, left, right, hazard}; one clock, model update, one check.
  task automatic step(input logic [4:0] v);
    int nm;
    {restart, brake, left, right, hazard} = v;
    @(posedge clka);
    cyc++;
    if (v[4]) begin
      m_rq    = 4'b0;
      m_mode  = M_IDLE;
      m_entry = cyc;
    end else begin
      nm = decode(m_rq);
      if (nm != m_mode) begin
        m_mode  = nm;
        m_entry = cyc;
      end
      m_rq = v[3:0];
    end
    @(negedge clka);
    check("model", 32'(observed()), 32'(model_out()));
  endtask

  task automatic hold(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  logic [2:0] lpat [4];
  logic [4:0] rv;
  int         len;

  initial begin
    lpat[0] = 3'b000; lpat[1] = 3'b100; lpat[2] = 3'b110; lpat[3] = 3'b111;
    {restart, brake, left, right, hazard} = 5'b10000;
    hold(5'b10000, 2);
    check("reset", 32'(observed()), 32'd0);

    // left held: sweep 000,100,110,111,000 with 4 clocks per phase
    step(5'b00100);
    for (int i = 1; i <= 20; i++) begin
      step(5'b00100);
      check("left_sweep", 32'(observed()), 32'({1'b0, lpat[((i - 1) / 4) % 4], 3'b000}));
    end
    hold(5'b00100, 16);
    check("auto_cancel", 32'(observed()), 32'd0);
    hold(5'b01100, 3);
    check("cancel_brake", 32'(observed()), 32'h3f);
    hold(5'b00000, 3);
    hold(5'b00100, 6);
    hold(5'b01100, 20);
    hold(5'b00100, 4);
    // error, then brake, then hazard override
    hold(5'b00110, 6);
    check("error", 32'(observed()), 32'h40);
    hold(5'b01110, 6);
    check("error_brake", 32'(observed()), 32'h7f);
    hold(5'b01111, 14);
    // restart mid-sequence with left held
    hold(5'b00000, 3);
    hold(5'b00100, 10);
    step(5'b10100);
    check("restart_mid", 32'(observed()), 32'd0);
    hold(5'b00100, 12);
    // right switched to left mid-sequence
    hold(5'b00010, 9);
    hold(5'b00100, 12);

    for (int s = 0; s < 60; s++) begin
      rv = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        step({1'b1, rv[3:0]});
      end else begin
        len = $urandom_range(1, 40);
        hold(rv, len);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
